// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data-memory block.
// Holds the RISC-V funct3 access encodings, the controller state type and
// a helper that classifies funct3 as legal for a load or a store.
package dmem_pkg;

  localparam int DATA_W = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    if (we)
      return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

endpackage

// File: rtl/dmem_if.sv
// dmem_if: request/response bus of the data memory.
// master: drives req_valid/req_we/req_funct3/req_addr/req_wdata and rsp_ready.
// slave : drives req_ready and rsp_valid/rsp_rdata/rsp_err.
interface dmem_if #(
  parameter int ADDR_W = 32
) ();
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: combinational byte-lane steering.
// Inputs : funct3, lane (addr[1:0]), wdata (right-aligned), rword (array word).
// Outputs: wbe/wlane (store byte enables and lane-positioned data),
//          rdata (extracted and extended load value), misalign flag.
// The lane is always forced to natural alignment; the caller decides whether
// a misaligned access is trapped via the misalign flag.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  wbe,
  output logic [31:0] wlane,
  output logic [31:0] rdata,
  output logic        misalign
);
  logic [1:0]         lane_eff;
  logic [31:0]        rsh;
  logic signed [7:0]  byte_s;
  logic signed [15:0] half_s;
  logic signed [31:0] byte_sx;
  logic signed [31:0] half_sx;

  always_comb begin
    lane_eff = lane;
    misalign = 1'b0;
    case (funct3[1:0])
      2'b01: begin
        misalign = lane[0];
        lane_eff = {lane[1], 1'b0};
      end
      2'b10: begin
        misalign = |lane;
        lane_eff = 2'b00;
      end
      default: ;
    endcase

    wlane = wdata << {lane_eff, 3'b000};
    case (funct3)
      F3_B:    wbe = 4'b0001 << lane_eff;
      F3_H:    wbe = 4'b0011 << lane_eff;
      F3_W:    wbe = 4'b1111;
      default: wbe = 4'b0000;
    endcase

    rsh     = rword >> {lane_eff, 3'b000};
    byte_s  = rsh[7:0];
    half_s  = rsh[15:0];
    byte_sx = byte_s;
    half_sx = half_s;
    case (funct3)
      F3_B:    rdata = byte_sx;
      F3_H:    rdata = half_sx;
      F3_W:    rdata = rword;
      F3_BU:   rdata = {24'd0, rsh[7:0]};
      F3_HU:   rdata = {16'd0, rsh[15:0]};
      default: rdata = 32'd0;
    endcase
  end
endmodule

// File: rtl/dmem_sys.sv
// dmem_sys: single-port byte-addressed little-endian data memory with a
// valid/ready request and response handshake (one access in flight).
// Ports: clkd, rst (sync, active-high), bus (dmem_if.slave).
// Optional build macro DMEM_MISALIGN_TRAP_EN: misaligned halfword/word
// accesses fault instead of being forced to alignment.
module dmem_sys
  import dmem_pkg::*;
#(
  parameter int DEPTH  = 512,
  parameter int ADDR_W = 32
) (
  input logic   clkd,
  input logic   rst,
  dmem_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH);
`ifdef DMEM_MISALIGN_TRAP_EN
  localparam bit TRAP_MISALIGN = 1'b1;
`else
  localparam bit TRAP_MISALIGN = 1'b0;
`endif

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state;
  logic              rdy_p0;
  logic              we_p0;
  logic [2:0]        f3_p0;
  logic [ADDR_W-1:0] addr_p0;
  logic [31:0]       wdata_p0;
  logic              vld_p1;
  logic [31:0]       rdata_p1;
  logic              err_p1;

  logic [IDX_W-1:0]  word_idx;
  logic [ADDR_W-1:0] addr_hi;
  logic [3:0]        wbe;
  logic [31:0]       wlane;
  logic [31:0]       rdata_ext;
  logic              misalign;
  logic              acc_err;
  logic              do_write;

  // Stage p0: request accepted from the bus
  always_ff @(posedge clkd) begin
    if (state == S_IDLE && bus.req_valid && rdy_p0) begin
      we_p0    <= bus.req_we;
      f3_p0    <= bus.req_funct3;
      addr_p0  <= bus.req_addr;
      wdata_p0 <= bus.req_wdata;
    end
  end

  always_comb begin
    word_idx = addr_p0[IDX_W+1:2];
    addr_hi  = addr_p0 >> (IDX_W + 2);
    acc_err  = (|addr_hi) || !f3_legal(we_p0, f3_p0) || (TRAP_MISALIGN && misalign);
    do_write = (state == S_ACCESS) && we_p0 && !acc_err && !rst;
  end

  dmem_lane_align u_align (
    .funct3   (f3_p0),
    .lane     (addr_p0[1:0]),
    .wdata    (wdata_p0),
    .rword    (mem[word_idx]),
    .wbe      (wbe),
    .wlane    (wlane),
    .rdata    (rdata_ext),
    .misalign (misalign)
  );

  always_ff @(posedge clkd) begin
    if (do_write) begin
      for (int i = 0; i < 4; i++) begin
        if (wbe[i]) mem[word_idx][8*i +: 8] <= wlane[8*i +: 8];
      end
    end
  end

  // Stage p1: registered response, held until the consumer takes it
  always_ff @(posedge clkd) begin
    if (rst) begin
      state    <= S_IDLE;
      rdy_p0   <= 1'b1;
      vld_p1   <= 1'b0;
      rdata_p1 <= 32'd0;
      err_p1   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.req_valid && rdy_p0) begin
            state  <= S_ACCESS;
            rdy_p0 <= 1'b0;
          end
        end
        S_ACCESS: begin
          rdata_p1 <= (acc_err || we_p0) ? 32'd0 : rdata_ext;
          err_p1   <= acc_err;
          vld_p1   <= 1'b1;
          state    <= S_RESP;
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            vld_p1 <= 1'b0;
            rdy_p0 <= 1'b1;
            state  <= S_IDLE;
          end
        end
        default: begin
          state  <= S_IDLE;
          rdy_p0 <= 1'b1;
          vld_p1 <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready = rdy_p0;
  assign bus.rsp_valid = vld_p1;
  assign bus.rsp_rdata = rdata_p1;
  assign bus.rsp_err   = err_p1;
endmodule

// File: tb/tb_dmem_sys.sv
// tb_dmem_sys: directed vector table, reset corner sequences and randomized
// traffic against a byte-array reference model of the data memory.
module tb_dmem_sys;
  localparam int DEPTH  = 512;
  localparam int ADDR_W = 32;

  logic clkd = 1'b0;
  logic rst  = 1'b1;
  always #5 clkd = ~clkd;

  dmem_if #(.ADDR_W(ADDR_W)) bus ();

  dmem_sys #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clkd (clkd),
    .rst  (rst),
    .bus  (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] ref_mem [0:4*DEPTH-1];

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Reference behaviour written from the memory's access rules.
  task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, output logic [31:0] rd, output logic err);
    int          size;
    logic [31:0] a;
    logic [31:0] v;
    bit          legal;
    rd  = 32'd0;
    err = 1'b0;
    legal = we ? (f3 <= 3'd2) : (f3 <= 3'd5 && f3 != 3'd3);
    if (!legal || addr >= 32'(4*DEPTH)) begin
      err = 1'b1;
      return;
    end
    size = 1 << f3[1:0];
    a = addr;
    if (a % size != 0) begin
`ifdef DMEM_MISALIGN_TRAP_EN
      err = 1'b1;
      return;
`else
      a = a - a % size;
`endif
    end
    if (we) begin
      for (int i = 0; i < size; i++) ref_mem[a+i] = wd[8*i +: 8];
    end else begin
      v = 32'd0;
      for (int i = 0; i < size; i++) v = v | (32'(ref_mem[a+i]) << (8*i));
      if (!f3[2] && size < 4 && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8*size));
      rd = v;
    end
  endtask

  task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wd, input int hold,
                      output logic [31:0] rd, output logic err);
    int n;
    rd  = 32'd0;
    err = 1'b0;
    @(negedge clkd);
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
    bus.req_valid  = 1'b1;
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 20) begin
      @(negedge clkd);
      n++;
    end
    if (n >= 20) begin
      n_chk++;
      n_fail++;
      $display("FAIL accept_timeout: req_ready stayed %b, expected 1", bus.req_ready);
      bus.req_valid = 1'b0;
      return;
    end
    @(posedge clkd);
    @(negedge clkd);
    bus.req_valid = 1'b0;
    chk("vld_one_cycle_after_accept", 32'(bus.rsp_valid), 32'd0);
    @(negedge clkd);
    chk("vld_two_cycles_after_accept", 32'(bus.rsp_valid), 32'd1);
    rd  = bus.rsp_rdata;
    err = bus.rsp_err;
    for (int i = 0; i < hold; i++) begin
      @(negedge clkd);
      chk("hold_vld", 32'(bus.rsp_valid), 32'd1);
      chk("hold_rdata", bus.rsp_rdata, rd);
      chk("hold_err", 32'(bus.rsp_err), 32'(err));
      chk("hold_req_ready", 32'(bus.req_ready), 32'd0);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clkd);
    bus.rsp_ready = 1'b0;
    chk("post_handshake_vld", 32'(bus.rsp_valid), 32'd0);
    chk("post_handshake_ready", 32'(bus.req_ready), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, mrd;
    logic        er, mer;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr, wd;

    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'd0;
    bus.req_addr   = '0;
    bus.req_wdata  = 32'd0;
    bus.rsp_ready  = 1'b0;

    vecs[0]  = '{1'b1, 3'b010, 32'h10, 32'h8000_00F0, 32'h0, 1'b0};
    vecs[1]  = '{1'b0, 3'b010, 32'h10, 32'h0, 32'h8000_00F0, 1'b0};
    vecs[2]  = '{1'b1, 3'b000, 32'h12, 32'hAB, 32'h0, 1'b0};
    vecs[3]  = '{1'b0, 3'b000, 32'h12, 32'h0, 32'hFFFF_FFAB, 1'b0};
    vecs[4]  = '{1'b0, 3'b100, 32'h12, 32'h0, 32'h0000_00AB, 1'b0};
    vecs[5]  = '{1'b0, 3'b010, 32'h10, 32'h0, 32'h80AB_00F0, 1'b0};
`ifdef DMEM_MISALIGN_TRAP_EN
    vecs[6]  = '{1'b1, 3'b001, 32'h13, 32'h1234, 32'h0, 1'b1};
    vecs[7]  = '{1'b0, 3'b010, 32'h10, 32'h0, 32'h80AB_00F0, 1'b0};
    vecs[12] = '{1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFF_80AB, 1'b0};
    vecs[13] = '{1'b0, 3'b101, 32'h12, 32'h0, 32'h0000_80AB, 1'b0};
    vecs[14] = '{1'b0, 3'b010, 32'h11, 32'h0, 32'h0, 1'b1};
`else
    vecs[6]  = '{1'b1, 3'b001, 32'h13, 32'h1234, 32'h0, 1'b0};
    vecs[7]  = '{1'b0, 3'b010, 32'h10, 32'h0, 32'h1234_00F0, 1'b0};
    vecs[12] = '{1'b0, 3'b001, 32'h12, 32'h0, 32'h0000_1234, 1'b0};
    vecs[13] = '{1'b0, 3'b101, 32'h13, 32'h0, 32'h0000_1234, 1'b0};
    vecs[14] = '{1'b0, 3'b010, 32'h11, 32'h0, 32'h1234_00F0, 1'b0};
`endif
    vecs[8]  = '{1'b0, 3'b010, 32'h800, 32'h0, 32'h0, 1'b1};
    vecs[9]  = '{1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1};
    vecs[10] = '{1'b1, 3'b100, 32'h10, 32'hFF, 32'h0, 1'b1};
    vecs[11] = '{1'b0, 3'b010, 32'hFFFF_0010, 32'h0, 32'h0, 1'b1};

    // reset state
    repeat (3) @(posedge clkd);
    @(negedge clkd);
    chk("reset_req_ready", 32'(bus.req_ready), 32'd1);
    chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("reset_rsp_rdata", bus.rsp_rdata, 32'd0);
    chk("reset_rsp_err", 32'(bus.rsp_err), 32'd0);
    rst = 1'b0;

    // directed vector table
    for (int i = 0; i < 15; i++) begin
      xact(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wd, 0, rd, er);
      model(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wd, mrd, mer);
      chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
      chk($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
    end

    // backpressure: response held five cycles
    xact(1'b0, 3'b010, 32'h10, 32'h0, 5, rd, er);
    model(1'b0, 3'b010, 32'h10, 32'h0, mrd, mer);
    chk("backpressure_rdata", rd, mrd);
    xact(1'b0, 3'b100, 32'h10, 32'h0, 0, rd, er);
    chk("after_backpressure_lbu", rd, 32'h0000_00F0);

    // reset during ACCESS suppresses the store
    xact(1'b1, 3'b010, 32'h20, 32'h1122_3344, 0, rd, er);
    model(1'b1, 3'b010, 32'h20, 32'h1122_3344, mrd, mer);
    @(negedge clkd);
    bus.req_we = 1'b1; bus.req_funct3 = 3'b010;
    bus.req_addr = 32'h20; bus.req_wdata = 32'hDEAD_BEEF;
    bus.req_valid = 1'b1;
    chk("abort_ready_before", 32'(bus.req_ready), 32'd1);
    @(posedge clkd);
    @(negedge clkd);
    bus.req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clkd);
    @(negedge clkd);
    rst = 1'b0;
    chk("abort_access_vld", 32'(bus.rsp_valid), 32'd0);
    chk("abort_access_ready", 32'(bus.req_ready), 32'd1);
    repeat (2) @(negedge clkd);
    chk("abort_access_vld_later", 32'(bus.rsp_valid), 32'd0);
    xact(1'b0, 3'b010, 32'h20, 32'h0, 0, rd, er);
    chk("abort_access_prior_contents", rd, 32'h1122_3344);

    // reset during RESP drops the response
    @(negedge clkd);
    bus.req_we = 1'b0; bus.req_funct3 = 3'b010;
    bus.req_addr = 32'h20; bus.req_valid = 1'b1;
    @(posedge clkd);
    @(negedge clkd);
    bus.req_valid = 1'b0;
    @(negedge clkd);
    chk("resp_rst_pre_vld", 32'(bus.rsp_valid), 32'd1);
    chk("resp_rst_pre_rdata", bus.rsp_rdata, 32'h1122_3344);
    rst = 1'b1;
    @(posedge clkd);
    @(negedge clkd);
    rst = 1'b0;
    chk("resp_rst_vld", 32'(bus.rsp_valid), 32'd0);
    chk("resp_rst_rdata", bus.rsp_rdata, 32'd0);
    chk("resp_rst_ready", 32'(bus.req_ready), 32'd1);

    // fill every word so the model is fully defined
    for (int w = 0; w < DEPTH; w++) begin
      wd = $urandom;
      xact(1'b1, 3'b010, 32'(4*w), wd, 0, rd, er);
      model(1'b1, 3'b010, 32'(4*w), wd, mrd, mer);
    end
    xact(1'b0, 3'b010, 32'(4*(DEPTH-1)), 32'h0, 0, rd, er);
    model(1'b0, 3'b010, 32'(4*(DEPTH-1)), 32'h0, mrd, mer);
    chk("last_word_rdata", rd, mrd);

    // randomized traffic
    for (int k = 0; k < 300; k++) begin
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 15) == 0) addr = $urandom | 32'h8000_0000;
      else addr = 32'($urandom_range(0, 4*DEPTH-1));
      wd = $urandom;
      xact(we, f3, addr, wd, $urandom_range(0, 2), rd, er);
      model(we, f3, addr, wd, mrd, mer);
      chk($sformatf("rand%0d_rdata", k), rd, mrd);
      chk($sformatf("rand%0d_err", k), 32'(er), 32'(mer));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dmem_sys.md
DMEM_SYS -- requirements
Module: dmem_sys

Interface
REQ-001 SHALL have parameter DEPTH, default 512, meaning number of 32-bit words (power of two, min 4).
REQ-002 SHALL have parameter ADDR_W, default 32, meaning byte-address width.
REQ-003 SHALL have these ports:
- clkd  input  1  clock; reset is synchronous and active-high.
- rst  input  1  synchronous active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request.
- req_we  input  1  1=store, 0=load.
- req_funct3  input  3  RISC-V funct3: LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010.
- req_addr  input  ADDR_W  byte address.
- req_wdata  input  32  store data, right-aligned.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer takes response.
- rsp_rdata  output  32  load result, extended; 0 for stores and errors.
- rsp_err  output  1  access fault.

Function
REQ-004 SHALL use three-state FSM IDLE, ACCESS, RESP; req_ready=1 only in IDLE.
REQ-005 SHALL accept a request at the clkd edge where req_valid&&req_ready, latching we, funct3, addr, wdata, and going IDLE->ACCESS.
REQ-006 In ACCESS, SHALL perform the array read or byte-lane write on the next edge, register rsp_rdata/rsp_err, and go to RESP; rsp_valid=1 two cycles after acceptance.
REQ-007 In RESP, SHALL hold rsp_valid, rsp_rdata and rsp_err stable until rsp_valid&&rsp_ready, then go to IDLE; no request is accepted in the same cycle.
REQ-008 Memory SHALL be byte-addressed little-endian: word index = addr[log2(DEPTH)+1:2], lane = addr[1:0].
REQ-009 Stores SHALL write only the addressed lanes: SB 1 byte, SH 2 bytes, SW 4 bytes; other bytes unchanged.
REQ-010 Loads SHALL extract the addressed lanes; LB/LH sign-extend, LBU/LHU zero-extend, LW returns the full word.
REQ-011 Address with any bit above the word-index range set SHALL give rsp_err=1, rsp_rdata=0, and no write.
REQ-012 Illegal funct3 (loads 011/110/111, stores 1xx/011) SHALL give rsp_err=1, rsp_rdata=0, and no write.
REQ-013 Misalignment handling SHALL follow REQ-017/018.
REQ-014 Memory contents SHALL be undefined at power-up and not cleared by rst.

Reset
REQ-015 rst SHALL force IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0 on the next edge.
REQ-016 rst asserted in ACCESS SHALL suppress the pending store write at that edge; rst in RESP SHALL drop the response.

Configuration
REQ-017 With DMEM_MISALIGN_TRAP_EN defined, LH/LHU/SH with addr[0]=1 or LW/SW with addr[1:0]!=0 SHALL give rsp_err=1, rsp_rdata=0, and no write.
REQ-018 Without DMEM_MISALIGN_TRAP_EN, the block SHALL force the low address bits to alignment (halfword clears addr[0], word clears addr[1:0]) and complete the access without error.

Structure
REQ-019 Package dmem_pkg SHALL hold the funct3 encoding constants and the FSM state typedef.
REQ-020 Sub-module dmem_lane_align (combinational) SHALL generate store byte-enables/lane data and load extraction/extension, with the misalignment flag as an output.

Verification
REQ-021 SW 0x8000_00F0 to addr 0x10, then LW 0x10 -> rsp_rdata=0x8000_00F0, rsp_err=0, rsp_valid two cycles after each acceptance.
REQ-022 After REQ-021, SB 0xAB to 0x12 then LB 0x12 -> 0xFFFF_FFAB; LBU 0x12 -> 0x0000_00AB; LW 0x10 -> 0x80AB_00F0.
REQ-023 SH 0x1234 to 0x13 with macro -> rsp_err=1, word 0x10 unchanged; without macro -> write lands at 0x12, LW 0x10 -> 0x1234_00F0.
REQ-024 LW to addr 4*DEPTH (0x800 at default) -> rsp_err=1, rsp_rdata=0; load funct3 011 -> rsp_err=1.
REQ-025 Hold rsp_ready=0 for 5 cycles -> rsp_valid/rsp_rdata stable and req_ready=0 throughout; a new request is accepted only after the handshake.
REQ-026 Assert rst during ACCESS of SW 0xDEAD_BEEF to 0x20 -> next edge IDLE, rsp_valid=0; LW 0x20 returns the prior contents.
